// File: rtl/column_loader.sv
// Column loader: fills a per-row shadow buffer from a byte stream and transfers
// it to the registered values bus on each column-sync pulse, or blanks on underrun.

module column_row #(
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_data,
    input  logic             load,
    input  logic             blank,
    output logic [DEPTH-1:0] value
);
    logic [DEPTH-1:0] shadow;

    // shadow survives a load so a repeated column needs no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            value  <= '0;
        end else begin
            if (wr_en)
                shadow <= wr_data;
            if (load)
                value <= shadow;
            else if (blank)
                value <= '0;
        end
    end
endmodule

module column_loader #(
    parameter int ROWS  = 32,
    parameter int DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  col_sync,
    output logic [ROWS*DEPTH-1:0] values,
    output logic                  col_loaded,
    output logic                  underrun
);
    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t                       state, state_nxt;
    logic [IDX_W-1:0]             idx, idx_nxt, slot;
    logic                         beat, load, blank;
    logic [ROWS-1:0][DEPTH-1:0]   vals;

    assign pix_ready = (state == FILL);
    assign beat      = pix_valid & pix_ready;
    assign slot      = pix_data[7] ? '0 : idx;
    assign load      = col_sync & (state == FULL);
    assign blank     = col_sync & (state == FILL);
    assign values    = vals;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= '0;
            col_loaded <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            col_loaded <= load;
            underrun   <= blank;
        end
    end

    // a beat coinciding with an underrun sync is still written
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            FILL: begin
                if (beat) begin
                    if (slot == LAST) begin
                        idx_nxt   = '0;
                        state_nxt = FULL;
                    end else begin
                        idx_nxt = slot + 1'b1;
                    end
                end
            end
            FULL: begin
                if (col_sync)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        column_row #(.DEPTH(DEPTH)) u_row (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (beat && (slot == IDX_W'(r))),
            .wr_data (pix_data[DEPTH-1:0]),
            .load    (load),
            .blank   (blank),
            .value   (vals[r])
        );
    end
endmodule

// File: tb/tb_column_loader.sv
// Scoreboard bench for column_loader: expected column results are queued when
// col_sync is driven and compared when the pulse comes back.

module tb_column_loader;
    localparam int ROWS  = 32;
    localparam int DEPTH = 5;
    localparam int W     = ROWS * DEPTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   pix_data = 8'h00;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic         col_sync = 1'b0;
    logic [W-1:0] values;
    logic         col_loaded;
    logic         underrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] vals;
        logic         loaded;
        logic         under;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] col_exp[ROWS];

    column_loader #(.ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .col_sync   (col_sync),
        .values     (values),
        .col_loaded (col_loaded),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] flat();
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[DEPTH*r +: DEPTH] = col_exp[r];
        return v;
    endfunction

    // inputs applied at a negedge, held across one posedge, sampled at next negedge
    task automatic cycle(input logic v, input logic [7:0] d, input logic s);
        pix_valid = v;
        pix_data  = d;
        col_sync  = s;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        col_sync  = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] v, input logic ld, input logic ur);
        exp_t e;
        e.vals = v; e.loaded = ld; e.under = ur;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (values !== e.vals || col_loaded !== e.loaded || underrun !== e.under) begin
            bad++;
            $display("FAIL %s: got values=%h loaded=%b under=%b want values=%h loaded=%b under=%b",
                     name, values, col_loaded, underrun, e.vals, e.loaded, e.under);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (values !== '0 || col_loaded !== 1'b0 || underrun !== 1'b0 || pix_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: values=%h loaded=%b under=%b ready=%b want 0/0/0/1",
                     values, col_loaded, underrun, pix_ready);
        end
    endtask

    task automatic test_full_load();
        for (int i = 0; i < ROWS; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            col_exp[i] = 5'(i);
        end
        total++;
        if (pix_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready: got %b want 0", pix_ready);
        end
        push_exp(flat(), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("full_load");
        total++;
        if (pix_ready !== 1'b1) begin
            bad++; $display("FAIL full_ready_after: got %b want 1", pix_ready);
        end
        cycle(1'b0, 8'h00, 1'b0);
        total++;
        if (col_loaded !== 1'b0 || values !== flat()) begin
            bad++; $display("FAIL full_pulse_width: loaded=%b values=%h", col_loaded, values);
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(31 - i), 1'b0);
            col_exp[i] = 5'(31 - i);
        end
        push_exp('0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("underrun_blank");
        total++;
        if (pix_ready !== 1'b1) begin
            bad++; $display("FAIL underrun_ready: got %b want 1", pix_ready);
        end
        cycle(1'b0, 8'h00, 1'b0);
        total++;
        if (underrun !== 1'b0) begin
            bad++; $display("FAIL underrun_pulse_width: got %b want 0", underrun);
        end
        for (int i = 10; i < ROWS; i++) begin
            cycle(1'b1, 8'(31 - i), 1'b0);
            col_exp[i] = 5'(31 - i);
        end
        push_exp(flat(), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("underrun_refill");
    endtask

    task automatic test_hold_full();
        int stalls;
        stalls = 0;
        for (int i = 0; i < ROWS; i++) begin
            cycle(1'b1, 8'((i * 7) & 31), 1'b0);
            col_exp[i] = 5'((i * 7) & 31);
        end
        for (int k = 0; k < 20; k++) begin
            if (pix_ready !== 1'b0) stalls++;
            cycle(1'b1, 8'h1F, 1'b0);
        end
        total++;
        if (stalls != 0) begin
            bad++; $display("FAIL hold_ready: ready high in %0d of 20 cycles, want 0", stalls);
        end
        push_exp(flat(), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("hold_full_load");
    endtask

    task automatic test_marker();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 1), 1'b0);
        cycle(1'b1, 8'h83, 1'b0);
        col_exp[0] = 5'd3;
        for (int i = 1; i < ROWS; i++) begin
            cycle(1'b1, 8'((i + 20) & 31), 1'b0);
            col_exp[i] = 5'((i + 20) & 31);
        end
        total++;
        if (pix_ready !== 1'b0) begin
            bad++; $display("FAIL marker_full: ready=%b want 0", pix_ready);
        end
        push_exp(flat(), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("marker_load");
    endtask

    task automatic test_coincident();
        for (int i = 0; i < ROWS - 1; i++) begin
            cycle(1'b1, 8'(i ^ 5'h15), 1'b0);
            col_exp[i] = 5'(i ^ 5'h15);
        end
        col_exp[ROWS-1] = 5'h0A;
        push_exp('0, 1'b0, 1'b1);
        cycle(1'b1, 8'h0A, 1'b1);
        pop_check("coincident_underrun");
        total++;
        if (pix_ready !== 1'b0) begin
            bad++; $display("FAIL coincident_full: ready=%b want 0", pix_ready);
        end
        push_exp(flat(), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("coincident_load");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i + 2), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (values !== '0 || pix_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset: values=%h ready=%b want 0/1", values, pix_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ROWS; i++) begin
            cycle(1'b1, 8'((i * 3 + 1) & 31), 1'b0);
            col_exp[i] = 5'((i * 3 + 1) & 31);
        end
        push_exp(flat(), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pop_check("post_reset_load");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_load();
        test_underrun();
        test_hold_full();
        test_marker();
        test_coincident();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
